// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall sequencer.
// State encoding and the per-stage control bundle.
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_bubble;
        logic exmem_we;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{
        pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_we: 1'b1,
        idex_bubble: 1'b0, exmem_we: 1'b1, memwb_bubble: 1'b0};

    localparam ctrl_t CTRL_LU = '{
        pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_we: 1'b1,
        idex_bubble: 1'b1, exmem_we: 1'b1, memwb_bubble: 1'b0};

    localparam ctrl_t CTRL_FREEZE = '{
        pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_we: 1'b0,
        idex_bubble: 1'b0, exmem_we: 1'b0, memwb_bubble: 1'b1};

    localparam ctrl_t CTRL_HALT = '{
        pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_we: 1'b0,
        idex_bubble: 1'b1, exmem_we: 1'b0, memwb_bubble: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls of pipeline_ctrl.
// master = pipeline/testbench side, slave = the sequencer.
interface pipeline_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             IDEX_MemRead_i;
    logic [REG_W-1:0] IDEX_RegRt_i;
    logic [REG_W-1:0] IFID_RegRs_i;
    logic [REG_W-1:0] IFID_RegRt_i;
    logic             BranchTaken_i;
    logic             MemReq_i;
    logic             MemReady_i;
    logic             PCWrite_o;
    logic             IFID_Write_o;
    logic             IFID_Flush_o;
    logic             IDEX_Write_o;
    logic             IDEX_Bubble_o;
    logic             EXMEM_Write_o;
    logic             MEMWB_Bubble_o;
    logic [CNT_W-1:0] StallCount_o;
    logic             Timeout_o;

    modport master (
        output IDEX_MemRead_i, IDEX_RegRt_i, IFID_RegRs_i, IFID_RegRt_i,
        output BranchTaken_i, MemReq_i, MemReady_i,
        input  PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o,
        input  IDEX_Bubble_o, EXMEM_Write_o, MEMWB_Bubble_o,
        input  StallCount_o, Timeout_o
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_RegRt_i, IFID_RegRs_i, IFID_RegRt_i,
        input  BranchTaken_i, MemReq_i, MemReady_i,
        output PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o,
        output IDEX_Bubble_o, EXMEM_Write_o, MEMWB_Bubble_o,
        output StallCount_o, Timeout_o
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use compare: the load in EX targets a source of the ID instruction.
// Register 0 never creates a hazard since it is hardwired to zero.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             mem_read_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    output logic             hazard_o
);
    assign hazard_o = mem_read_i
                    & (idex_rt_i != '0)
                    & ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer: memory wait > load-use > branch flush.
// Also keeps a saturating stall counter and a sticky memory-timeout flag.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input logic           Clock_i,
    input logic           Reset_n_i,
    pipeline_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ctrl_t             ctrl;
    logic              hazard;
    logic              memstall;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .mem_read_i (bus.IDEX_MemRead_i),
        .idex_rt_i  (bus.IDEX_RegRt_i),
        .ifid_rs_i  (bus.IFID_RegRs_i),
        .ifid_rt_i  (bus.IFID_RegRt_i),
        .hazard_o   (hazard)
    );

    assign memstall = bus.MemReq_i & ~bus.MemReady_i;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ctrl    = CTRL_RUN;
        unique case (state_q)
            RUN, LU_STALL: begin
                state_d = RUN;
                if (memstall) begin
                    ctrl    = CTRL_FREEZE;
                    wait_d  = WAIT_W'(1);
                    state_d = MEM_WAIT;
                end else if (state_q == RUN && hazard) begin
                    // Branch is re-seen next cycle because IF/ID is held
                    ctrl    = CTRL_LU;
                    state_d = LU_STALL;
                end else if (bus.BranchTaken_i) begin
                    ctrl.ifid_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                ctrl = CTRL_FREEZE;
                if (bus.MemReady_i) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ERROR: ctrl = CTRL_HALT;
            default: ctrl = CTRL_HALT;
        endcase
        if (!Reset_n_i) begin
            ctrl = CTRL_HALT;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!ctrl.pc_we && state_q != ERROR && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= RUN;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PCWrite_o      = ctrl.pc_we;
    assign bus.IFID_Write_o   = ctrl.ifid_we;
    assign bus.IFID_Flush_o   = ctrl.ifid_flush;
    assign bus.IDEX_Write_o   = ctrl.idex_we;
    assign bus.IDEX_Bubble_o  = ctrl.idex_bubble;
    assign bus.EXMEM_Write_o  = ctrl.exmem_we;
    assign bus.MEMWB_Bubble_o = ctrl.memwb_bubble;
    assign bus.StallCount_o   = cnt_q;
    assign bus.Timeout_o      = (state_q == ERROR);
endmodule
